// File: rtl/main_memory_arbiter_if.sv
// main_memory_arbiter_if
// Bundles the two requester ports, the freeze control and the memory-side
// port of main_memory_arbiter.
//   m0_*/m1_*  : requester address, byteenable, read/write strobes and
//                writedata in; waitrequest, readdata and readdatavalid out
//   freeze     : stops new grants while high
//   mem_*      : address/byteenable/chipselect/write/writedata/clken out to
//                a synchronous memory, readdata back (one-cycle latency)
// Modports:
//   slave  : the arbiter side
//   master : the requester/memory environment side
interface main_memory_arbiter_if #(
  parameter int AW = 14
);
  logic [AW-1:0] m0_address;
  logic [3:0]    m0_byteenable;
  logic          m0_read;
  logic          m0_write;
  logic [31:0]   m0_writedata;
  logic          m0_waitrequest;
  logic [31:0]   m0_readdata;
  logic          m0_readdatavalid;

  logic [AW-1:0] m1_address;
  logic [3:0]    m1_byteenable;
  logic          m1_read;
  logic          m1_write;
  logic [31:0]   m1_writedata;
  logic          m1_waitrequest;
  logic [31:0]   m1_readdata;
  logic          m1_readdatavalid;

  logic          freeze;

  logic [AW-1:0] mem_address;
  logic [3:0]    mem_byteenable;
  logic          mem_chipselect;
  logic          mem_write;
  logic [31:0]   mem_writedata;
  logic          mem_clken;
  logic [31:0]   mem_readdata;

  modport slave (
    input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  freeze,
    output mem_address, mem_byteenable, mem_chipselect, mem_write,
           mem_writedata, mem_clken,
    input  mem_readdata
  );

  modport master (
    output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    output freeze,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write,
           mem_writedata, mem_clken,
    output mem_readdata
  );
endinterface

// File: rtl/main_memory_arbiter.sv
// main_memory_arbiter
// Two-requester arbiter in front of a single-port synchronous memory of
// DEPTH 32-bit words. One request is granted per cycle (combinational
// waitrequest), reads return exactly one cycle after their grant through a
// one-entry return register, and addresses >= DEPTH are out-of-bounds
// (writes dropped, reads return zero).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : main_memory_arbiter_if.slave (requesters, freeze, memory port)
// Configuration:
//   MAIN_MEM_ARB_ROUND_ROBIN_EN - when defined, contention goes to the
//   requester that did not win last time; otherwise m0 always wins.
module main_memory_arbiter #(
  parameter int DEPTH = 10024,
  parameter int AW    = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  main_memory_arbiter_if.slave bus
);

`ifdef MAIN_MEM_ARB_ROUND_ROBIN_EN
  localparam bit ROUND_ROBIN = 1'b1;
`else
  localparam bit ROUND_ROBIN = 1'b0;
`endif

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_e;

  owner_e        last_grant;
  owner_e        grant_owner;
  owner_e        ret_owner;
  logic          ret_valid;
  logic          ret_oob;

  logic          m0_pending;
  logic          m1_pending;
  logic          m0_wins;
  logic          grant_any;
  logic          grant_write;
  logic          grant_oob;
  logic [AW-1:0] grant_address;
  logic [3:0]    grant_byteenable;
  logic [31:0]   grant_writedata;
  logic          m0_owns_return;
  logic          m1_owns_return;

  // Pick a winner. Without round robin last_grant is still tracked but the
  // tie-break collapses to "m0 wins".
  always_comb begin
    m0_pending  = bus.m0_read | bus.m0_write;
    m1_pending  = bus.m1_read | bus.m1_write;
    m0_wins     = !ROUND_ROBIN || (last_grant == OWNER_M1);
    grant_any   = !reset && !bus.freeze && (m0_pending || m1_pending);
    grant_owner = (m0_pending && (m0_wins || !m1_pending)) ? OWNER_M0 : OWNER_M1;
  end

  // Route the winner's request; read+write together counts as a write
  // because the write strobe alone selects the memory operation.
  always_comb begin
    if (grant_owner == OWNER_M0) begin
      grant_address    = bus.m0_address;
      grant_byteenable = bus.m0_byteenable;
      grant_writedata  = bus.m0_writedata;
      grant_write      = bus.m0_write;
    end else begin
      grant_address    = bus.m1_address;
      grant_byteenable = bus.m1_byteenable;
      grant_writedata  = bus.m1_writedata;
      grant_write      = bus.m1_write;
    end
    grant_oob = 32'(grant_address) >= DEPTH_U;
  end

  // Return register and grant history. Reset is asynchronous so a read
  // granted just before reset never produces readdatavalid afterwards;
  // last_grant resets to m1 so m0 wins the first round-robin contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ret_valid  <= 1'b0;
      ret_owner  <= OWNER_M0;
      ret_oob    <= 1'b0;
      last_grant <= OWNER_M1;
    end else begin
      ret_valid <= grant_any && !grant_write;
      if (grant_any) begin
        last_grant <= grant_owner;
        ret_owner  <= grant_owner;
        ret_oob    <= grant_oob;
      end
    end
  end

  assign m0_owns_return = ret_valid && (ret_owner == OWNER_M0);
  assign m1_owns_return = ret_valid && (ret_owner == OWNER_M1);

  // Only a pending requester that lost (or any requester during reset) waits.
  assign bus.m0_waitrequest = reset || (m0_pending && !(grant_any && grant_owner == OWNER_M0));
  assign bus.m1_waitrequest = reset || (m1_pending && !(grant_any && grant_owner == OWNER_M1));

  // Out-of-bounds writes are accepted but never reach the memory.
  assign bus.mem_chipselect = grant_any && !(grant_write && grant_oob);
  assign bus.mem_write      = grant_any && grant_write && !grant_oob;
  assign bus.mem_address    = grant_address;
  assign bus.mem_byteenable = grant_byteenable;
  assign bus.mem_writedata  = grant_writedata;

  // Keep the memory clocked during freeze until an outstanding read lands.
  assign bus.mem_clken = !bus.freeze || ret_valid;

  assign bus.m0_readdatavalid = m0_owns_return;
  assign bus.m1_readdatavalid = m1_owns_return;
  assign bus.m0_readdata      = (m0_owns_return && !ret_oob) ? bus.mem_readdata : 32'h0;
  assign bus.m1_readdata      = (m1_owns_return && !ret_oob) ? bus.mem_readdata : 32'h0;

endmodule

// File: tb/tb_main_memory_arbiter.sv
// tb_main_memory_arbiter
// Directed bench for main_memory_arbiter with a behavioural synchronous
// memory (byte-lane writes, one-cycle registered read). Expectations follow
// MAIN_MEM_ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_main_memory_arbiter;

  localparam int DEPTH = 10024;
  localparam int AW    = 14;

`ifdef MAIN_MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] mem_model [0:(1<<AW)-1];

  main_memory_arbiter_if #(.AW(AW)) bus ();

  main_memory_arbiter #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory; the word just past DEPTH holds a non-zero pattern so
  // out-of-bounds reads prove the arbiter masks the data.
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem_model[i] = 32'h0;
    mem_model[DEPTH] = 32'hFFFF_FFFF;
    bus.mem_readdata = 32'h0;
  end

  always @(posedge clk) begin
    if (bus.mem_clken && bus.mem_chipselect) begin
      if (bus.mem_write) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_byteenable[b]) mem_model[bus.mem_address][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
      end
      bus.mem_readdata <= mem_model[bus.mem_address];
    end
  end

  // Drive one cycle of requests at the falling edge, then let outputs settle.
  task automatic applyStimulus(
    input logic        r0, input logic w0, input logic [AW-1:0] a0,
    input logic [31:0] d0, input logic [3:0] be0,
    input logic        r1, input logic w1, input logic [AW-1:0] a1,
    input logic [31:0] d1, input logic [3:0] be1,
    input logic        frz
  );
    @(negedge clk);
    bus.m0_read = r0; bus.m0_write = w0; bus.m0_address = a0;
    bus.m0_writedata = d0; bus.m0_byteenable = be0;
    bus.m1_read = r1; bus.m1_write = w1; bus.m1_address = a1;
    bus.m1_writedata = d1; bus.m1_byteenable = be1;
    bus.freeze = frz;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    logic exp_m0;
    logic prev_m0;
    checks = 0;
    errors = 0;
    reset  = 1'b1;

    // Reset state.
    applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 0);
    checkOutput("rst_m0_wait", 32'(bus.m0_waitrequest), 32'd1);
    checkOutput("rst_m1_wait", 32'(bus.m1_waitrequest), 32'd1);
    checkOutput("rst_m0_rdv", 32'(bus.m0_readdatavalid), 32'd0);
    checkOutput("rst_m1_rdv", 32'(bus.m1_readdatavalid), 32'd0);
    checkOutput("rst_cs", 32'(bus.mem_chipselect), 32'd0);
    checkOutput("rst_mem_write", 32'(bus.mem_write), 32'd0);
    reset = 1'b0;

    // m0 writes, m1 reads back with one-cycle latency.
    applyStimulus(0, 1, 14'h0010, 32'hDEADBEEF, 4'hF, 0, 0, '0, '0, '0, 0);
    checkOutput("wr_m0_wait", 32'(bus.m0_waitrequest), 32'd0);
    checkOutput("wr_cs", 32'(bus.mem_chipselect), 32'd1);
    checkOutput("wr_mem_write", 32'(bus.mem_write), 32'd1);
    checkOutput("wr_addr", 32'(bus.mem_address), 32'h10);
    checkOutput("wr_data", bus.mem_writedata, 32'hDEADBEEF);
    applyStimulus(0, 0, '0, '0, '0, 1, 0, 14'h0010, '0, '0, 0);
    checkOutput("rd_m1_wait", 32'(bus.m1_waitrequest), 32'd0);
    checkOutput("rd_m0_idle_wait", 32'(bus.m0_waitrequest), 32'd0);
    checkOutput("rd_mem_write", 32'(bus.mem_write), 32'd0);
    checkOutput("rd_m1_rdv_early", 32'(bus.m1_readdatavalid), 32'd0);
    applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 0);
    checkOutput("rd_m1_rdv", 32'(bus.m1_readdatavalid), 32'd1);
    checkOutput("rd_m1_data", bus.m1_readdata, 32'hDEADBEEF);
    checkOutput("rd_m0_rdv_nonowner", 32'(bus.m0_readdatavalid), 32'd0);
    checkOutput("rd_m0_data_nonowner", bus.m0_readdata, 32'h0);

    // Six cycles of contention; last grant was m1.
    prev_m0 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      exp_m0 = RR ? (k % 2 == 0) : 1'b1;
      applyStimulus(1, 0, 14'h0010, '0, '0, 1, 0, 14'h0020, '0, '0, 0);
      checkOutput($sformatf("cont%0d_m0_wait", k), 32'(bus.m0_waitrequest), 32'(!exp_m0));
      checkOutput($sformatf("cont%0d_m1_wait", k), 32'(bus.m1_waitrequest), 32'(exp_m0));
      if (k > 0)
        checkOutput($sformatf("cont%0d_m0_rdv", k), 32'(bus.m0_readdatavalid), 32'(prev_m0));
      prev_m0 = exp_m0;
    end
    applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 0);
    checkOutput("cont_last_m0_rdv", 32'(bus.m0_readdatavalid), 32'(!RR));
    checkOutput("cont_last_m1_rdv", 32'(bus.m1_readdatavalid), 32'(RR));

    // Partial byte-lane write.
    applyStimulus(1, 1, 14'h0030, 32'hAAAAAAAA, 4'hF, 0, 0, '0, '0, '0, 0);
    checkOutput("be_rw_as_write", 32'(bus.mem_write), 32'd1);
    applyStimulus(0, 1, 14'h0030, 32'h11223344, 4'h3, 0, 0, '0, '0, '0, 0);
    applyStimulus(1, 0, 14'h0030, '0, '0, 0, 0, '0, '0, '0, 0);
    applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 0);
    checkOutput("be_rdv", 32'(bus.m0_readdatavalid), 32'd1);
    checkOutput("be_data", bus.m0_readdata, 32'hAAAA3344);

    // Out-of-bounds read and write.
    applyStimulus(1, 0, 14'(DEPTH), '0, '0, 0, 0, '0, '0, '0, 0);
    checkOutput("oob_rd_wait", 32'(bus.m0_waitrequest), 32'd0);
    applyStimulus(0, 0, '0, '0, '0, 0, 1, 14'h3FFF, 32'h12345678, 4'hF, 0);
    checkOutput("oob_rd_rdv", 32'(bus.m0_readdatavalid), 32'd1);
    checkOutput("oob_rd_data", bus.m0_readdata, 32'h0);
    checkOutput("oob_wr_wait", 32'(bus.m1_waitrequest), 32'd0);
    checkOutput("oob_wr_cs", 32'(bus.mem_chipselect), 32'd0);
    applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 0);
    checkOutput("oob_wr_no_rdv", 32'(bus.m1_readdatavalid), 32'd0);

    // Freeze right after an m0 read grant.
    applyStimulus(1, 0, 14'h0010, '0, '0, 0, 0, '0, '0, '0, 0);
    checkOutput("frz_grant_wait", 32'(bus.m0_waitrequest), 32'd0);
    applyStimulus(0, 0, '0, '0, '0, 1, 0, 14'h0030, '0, '0, 1);
    checkOutput("frz_m0_rdv", 32'(bus.m0_readdatavalid), 32'd1);
    checkOutput("frz_m0_data", bus.m0_readdata, 32'hDEADBEEF);
    checkOutput("frz_m1_wait", 32'(bus.m1_waitrequest), 32'd1);
    checkOutput("frz_cs", 32'(bus.mem_chipselect), 32'd0);
    applyStimulus(0, 0, '0, '0, '0, 1, 0, 14'h0030, '0, '0, 1);
    checkOutput("frz2_m1_wait", 32'(bus.m1_waitrequest), 32'd1);
    checkOutput("frz2_m0_rdv", 32'(bus.m0_readdatavalid), 32'd0);
    checkOutput("frz2_clken", 32'(bus.mem_clken), 32'd0);
    applyStimulus(0, 0, '0, '0, '0, 1, 0, 14'h0030, '0, '0, 0);
    checkOutput("unfrz_m1_wait", 32'(bus.m1_waitrequest), 32'd0);
    applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 0);
    checkOutput("unfrz_m1_rdv", 32'(bus.m1_readdatavalid), 32'd1);
    checkOutput("unfrz_m1_data", bus.m1_readdata, 32'hAAAA3344);

    // Reset lands before the edge that would return an m0 read.
    applyStimulus(1, 0, 14'h0010, '0, '0, 0, 0, '0, '0, '0, 0);
    checkOutput("prerst_wait", 32'(bus.m0_waitrequest), 32'd0);
    #2 reset = 1'b1;
    #1;
    checkOutput("inrst_m0_wait", 32'(bus.m0_waitrequest), 32'd1);
    checkOutput("inrst_cs", 32'(bus.mem_chipselect), 32'd0);
    applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 0);
    checkOutput("inrst_m0_rdv", 32'(bus.m0_readdatavalid), 32'd0);
    reset = 1'b0;
    applyStimulus(1, 0, 14'h0010, '0, '0, 1, 0, 14'h0030, '0, '0, 0);
    checkOutput("postrst_m0_rdv", 32'(bus.m0_readdatavalid), 32'd0);
    checkOutput("postrst_m0_wait", 32'(bus.m0_waitrequest), 32'd0);
    checkOutput("postrst_m1_wait", 32'(bus.m1_waitrequest), 32'd1);
    applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 0);
    checkOutput("postrst_rdv", 32'(bus.m0_readdatavalid), 32'd1);
    checkOutput("postrst_data", bus.m0_readdata, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
